// File: rtl/button_repeat.sv
`default_nettype none
// ============================================================================
// Module   : button_repeat
// Purpose  : Turns debounced button strobes into one-tick press, auto-repeat,
//            release and double-tap events, and counts the repeats of the
//            current hold (saturating at 255).
// Revision : 1.0 - initial release
// ============================================================================
module button_repeat #(
    parameter int DELAY_CYCLES = 50_000_000,
    parameter int RATE_CYCLES  = 10_000_000,
    parameter int DTAP_CYCLES  = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_lvl,
    input  logic       i_btn_ondn,
    input  logic       i_btn_onup,
    output logic       o_press,
    output logic       o_rpt,
    output logic       o_release,
    output logic       o_dtap,
    output logic       o_held,
    output logic [7:0] o_rpt_cnt
);

    // Timing counter spans the longer of the two periods; it never needs to
    // hold the period value itself because it clears at period-1.
    localparam int c_MAX_PERIOD = (DELAY_CYCLES > RATE_CYCLES) ? DELAY_CYCLES : RATE_CYCLES;
    localparam int c_TW         = (c_MAX_PERIOD > 1) ? $clog2(c_MAX_PERIOD) : 1;
    // Gap counter must be able to hold DTAP_CYCLES, its saturation value.
    localparam int c_GW         = $clog2(DTAP_CYCLES + 1);

    localparam logic [c_TW-1:0] c_T_ZERO     = '0;
    localparam logic [c_TW-1:0] c_T_ONE      = c_TW'(1);
    localparam logic [c_TW-1:0] c_DELAY_LAST = c_TW'(DELAY_CYCLES - 1);
    localparam logic [c_TW-1:0] c_RATE_LAST  = c_TW'(RATE_CYCLES - 1);
    localparam logic [c_GW-1:0] c_G_ZERO     = '0;
    localparam logic [c_GW-1:0] c_G_ONE      = c_GW'(1);
    localparam logic [c_GW-1:0] c_GAP_MAX    = c_GW'(DTAP_CYCLES);
    localparam logic [7:0]      c_CNT_MAX    = 8'hFF;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DELAY  = 2'd1;
    localparam logic [1:0] c_ST_REPEAT = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state;
    logic [c_TW-1:0] r_tcnt;
    logic [c_TW-1:0] w_tcnt;
    logic [c_GW-1:0] r_gap;
    logic [c_GW-1:0] w_gap;
    logic            r_press;
    logic            w_press;
    logic            r_rpt;
    logic            w_rpt;
    logic            r_release;
    logic            w_release;
    logic            r_dtap;
    logic            w_dtap;
    logic            r_held;
    logic            w_held;
    logic [7:0]      r_rpt_cnt;
    logic [7:0]      w_rpt_cnt;
    logic [7:0]      w_rpt_cnt_inc;
    logic [c_TW-1:0] w_period_last;

    // Saturating successor of the repeat count.
    assign w_rpt_cnt_inc = (r_rpt_cnt == c_CNT_MAX) ? r_rpt_cnt : r_rpt_cnt + 8'd1;
    // The first repeat waits the initial delay, later ones the repeat rate.
    assign w_period_last = (r_state == c_ST_DELAY) ? c_DELAY_LAST : c_RATE_LAST;

    // Next-state and next-output decode.
    always_comb begin
        w_state   = r_state;
        w_tcnt    = r_tcnt;
        w_gap     = r_gap;
        w_press   = 1'b0;
        w_rpt     = 1'b0;
        w_release = 1'b0;
        w_dtap    = 1'b0;
        w_held    = r_held;
        w_rpt_cnt = r_rpt_cnt;
        case (r_state)
            c_ST_IDLE: begin
                // The gap stays at zero during the release pulse itself, so a
                // press k cycles after the release sees a gap of k-1.
                if (!r_release && (r_gap != c_GAP_MAX)) begin
                    w_gap = r_gap + c_G_ONE;
                end
                if (i_btn_ondn) begin
                    w_state   = c_ST_DELAY;
                    w_tcnt    = c_T_ZERO;
                    w_rpt_cnt = 8'd0;
                    w_press   = 1'b1;
                    w_held    = 1'b1;
                    w_dtap    = (r_gap < c_GAP_MAX);
                end
            end
            c_ST_DELAY, c_ST_REPEAT: begin
                // A release strobe or a dropped level both end the hold; a
                // repeat that would coincide with the release is dropped.
                if (i_btn_onup || !i_btn_lvl) begin
                    w_state   = c_ST_IDLE;
                    w_tcnt    = c_T_ZERO;
                    w_gap     = c_G_ZERO;
                    w_release = 1'b1;
                    w_held    = 1'b0;
                end else if (r_tcnt == w_period_last) begin
                    w_state   = c_ST_REPEAT;
                    w_tcnt    = c_T_ZERO;
                    w_rpt     = 1'b1;
                    w_rpt_cnt = w_rpt_cnt_inc;
                end else begin
                    w_tcnt = r_tcnt + c_T_ONE;
                end
            end
            default: begin
                w_state = c_ST_IDLE;
                w_tcnt  = c_T_ZERO;
                w_held  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Counters and registered outputs; the gap resets saturated so the first
    // press after reset is never a double-tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt    <= c_T_ZERO;
            r_gap     <= c_GAP_MAX;
            r_press   <= 1'b0;
            r_rpt     <= 1'b0;
            r_release <= 1'b0;
            r_dtap    <= 1'b0;
            r_held    <= 1'b0;
            r_rpt_cnt <= 8'd0;
        end else begin
            r_tcnt    <= w_tcnt;
            r_gap     <= w_gap;
            r_press   <= w_press;
            r_rpt     <= w_rpt;
            r_release <= w_release;
            r_dtap    <= w_dtap;
            r_held    <= w_held;
            r_rpt_cnt <= w_rpt_cnt;
        end
    end

    assign o_press   = r_press;
    assign o_rpt     = r_rpt;
    assign o_release = r_release;
    assign o_dtap    = r_dtap;
    assign o_held    = r_held;
    assign o_rpt_cnt = r_rpt_cnt;

endmodule
`default_nettype wire
